cla_adder: RTL and testbench

- Parameterized registered carry-lookahead adder: sum = a + b + cin over WIDTH bits, plus carry-out.
- The datapath uses 4-bit lookahead groups. A second-level lookahead unit combines the group generate/propagate signals.
- Used as the final accumulation adder inside the Vedic multiplier partial-product tree.
- Instances: WIDTH=4 and WIDTH=6.

---
 rtl/adder_pkg.sv | 34 +++
 rtl/cla_adder_if.sv | 25 ++
 rtl/cla_group4.sv | 34 +++
 rtl/cla_adder.sv | 82 ++++++++
 tb/tb_cla_adder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the carry-lookahead adder: group sizing and
// a flattened sum-of-products carry function used at both lookahead levels.
package adder_pkg;

    localparam int GROUP_W = 4;
    localparam int MAX_W   = 32;

    function automatic int group_count(input int width);
        return (width + GROUP_W - 1) / GROUP_W;
    endfunction

    // Carry out of position n-1 written as an OR of independent product terms
    // (cin & p[n-1:0]) | (g[j] & p[n-1:j+1]), so no term waits on another carry.
    function automatic logic lookahead_carry(input logic [MAX_W-1:0] g,
                                             input logic [MAX_W-1:0] p,
                                             input logic             cin,
                                             input int               n);
        logic carry;
        logic prod;
        carry = cin;
        for (int k = 0; k < n; k++) begin
            carry = carry & p[k];
        end
        for (int j = 0; j < n; j++) begin
            prod = g[j];
            for (int k = j + 1; k < n; k++) begin
                prod = prod & p[k];
            end
            carry = carry | prod;
        end
        return carry;
    endfunction

endpackage

// File: rtl/cla_adder_if.sv
// Operand/result bundle for cla_adder; the producer drives operands, the adder
// drives the registered result. No ready signal: one operation per cycle.
interface cla_adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             g_out;
    logic             p_out;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum, cout, g_out, p_out
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum, cout, g_out, p_out
    );
endinterface

// File: rtl/cla_group4.sv
// Combinational lookahead group (up to 4 bits): sum plus group generate/propagate.
// Zero latency, no flow control; W narrows it for the partial tail group.
module cla_group4
    import adder_pkg::*;
#(
    parameter int W = GROUP_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_g,
    output logic         o_p
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W-1:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_c = '0;
        for (int i = 0; i < W; i++) begin
            w_c[i] = lookahead_carry(MAX_W'(w_g), MAX_W'(w_p), i_cin, i);
        end
    end

    assign o_sum = w_p ^ w_c;
    assign o_g   = lookahead_carry(MAX_W'(w_g), MAX_W'(w_p), 1'b0, W);
    assign o_p   = &w_p;

endmodule

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: sum/cout plus word G/P for cascading.
// Latency 1 cycle; no backpressure, accepts a new operation every cycle.
module cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    cla_adder_if.slave  bus
);

    localparam int NG = group_count(WIDTH);

    logic [NG-1:0]    w_grp_g;
    logic [NG-1:0]    w_grp_p;
    logic [NG-1:0]    w_grp_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_word_g;
    logic             w_word_p;
    logic             w_cout;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_g_out;
    logic             r_p_out;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int LO = k * GROUP_W;
        localparam int GW = ((WIDTH - LO) < GROUP_W) ? (WIDTH - LO) : GROUP_W;

        cla_group4 #(
            .W (GW)
        ) u_grp (
            .i_a   (bus.a[LO +: GW]),
            .i_b   (bus.b[LO +: GW]),
            .i_cin (w_grp_cin[k]),
            .o_sum (w_sum[LO +: GW]),
            .o_g   (w_grp_g[k]),
            .o_p   (w_grp_p[k])
        );
    end

    // Second level: every group carry-in is its own product-term expansion
    // over the group G/P, so group carries never ripple.
    always_comb begin
        w_grp_cin = '0;
        for (int k = 0; k < NG; k++) begin
            w_grp_cin[k] = lookahead_carry(MAX_W'(w_grp_g), MAX_W'(w_grp_p), bus.cin, k);
        end
    end

    assign w_word_g = lookahead_carry(MAX_W'(w_grp_g), MAX_W'(w_grp_p), 1'b0, NG);
    assign w_word_p = &w_grp_p;
    assign w_cout   = w_word_g | (w_word_p & bus.cin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_g_out     <= 1'b0;
            r_p_out     <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum   <= w_sum;
                r_cout  <= w_cout;
                r_g_out <= w_word_g;
                r_p_out <= w_word_p;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.g_out     = r_g_out;
    assign bus.p_out     = r_p_out;

endmodule

// File: tb/tb_cla_adder.sv
// Directed bench for cla_adder at WIDTH=4 and WIDTH=6, plus a full WIDTH=4 sweep.
module tb_cla_adder;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cla_adder_if #(.WIDTH(4)) bus4 ();
    cla_adder_if #(.WIDTH(6)) bus6 ();

    cla_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    cla_adder #(.WIDTH(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        bus4.in_valid = 1'b1;
        bus4.a        = a;
        bus4.b        = b;
        bus4.cin      = cin;
    endtask

    task automatic drive6(input logic [5:0] a, input logic [5:0] b, input logic cin);
        bus6.in_valid = 1'b1;
        bus6.a        = a;
        bus6.b        = b;
        bus6.cin      = cin;
    endtask

    task automatic chk6(input string tag, input logic [5:0] s, input logic c);
        chk({tag, "_vld"},  bus6.out_valid, 1'b1);
        chk({tag, "_sum"},  bus6.sum, s);
        chk({tag, "_cout"}, bus6.cout, c);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ref_full;
        logic [4:0] ref_gen;

        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus6.in_valid = 1'b0; bus6.a = '0; bus6.b = '0; bus6.cin = 1'b0;
        #2;
        chk("rst4_vld",  bus4.out_valid, 1'b0);
        chk("rst4_sum",  bus4.sum, 4'h0);
        chk("rst4_cout", bus4.cout, 1'b0);
        chk("rst4_g",    bus4.g_out, 1'b0);
        chk("rst4_p",    bus4.p_out, 1'b0);
        chk("rst6_vld",  bus6.out_valid, 1'b0);
        chk("rst6_sum",  bus6.sum, 6'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // WIDTH=4 directed vectors
        drive4(4'b1010, 4'b0110, 1'b0); tick();
        chk("w4_v1_vld", bus4.out_valid, 1'b1);
        chk("w4_v1_sum", bus4.sum, 4'b0000);
        chk("w4_v1_cout", bus4.cout, 1'b1);
        chk("w4_v1_p", bus4.p_out, 1'b0);
        drive4(4'b1010, 4'b0110, 1'b1); tick();
        chk("w4_v2_sum", bus4.sum, 4'b0001);
        chk("w4_v2_cout", bus4.cout, 1'b1);
        drive4(4'b1100, 4'b1111, 1'b1); tick();
        chk("w4_v3_sum", bus4.sum, 4'b1100);
        chk("w4_v3_cout", bus4.cout, 1'b1);
        drive4(4'b1100, 4'b1111, 1'b0); tick();
        chk("w4_v4_sum", bus4.sum, 4'b1011);
        chk("w4_v4_cout", bus4.cout, 1'b1);
        chk("w4_v4_g", bus4.g_out, 1'b1);
        bus4.in_valid = 1'b0;

        // WIDTH=6 back-to-back, one result per cycle
        drive6(6'b101010, 6'b100110, 1'b0); tick(); chk6("w6_v1", 6'b010000, 1'b1);
        drive6(6'b101110, 6'b100110, 1'b1); tick(); chk6("w6_v2", 6'b010101, 1'b1);
        drive6(6'b110100, 6'b001111, 1'b1); tick(); chk6("w6_v3", 6'b000100, 1'b1);
        drive6(6'b001100, 6'b011111, 1'b0); tick(); chk6("w6_v4", 6'b101011, 1'b0);

        // Full propagate path through both groups
        drive6(6'b101010, 6'b010101, 1'b1); tick();
        chk6("w6_prop", 6'b000000, 1'b1);
        chk("w6_prop_p", bus6.p_out, 1'b1);
        chk("w6_prop_g", bus6.g_out, 1'b0);

        drive6(6'b111111, 6'b111111, 1'b1); tick();
        chk6("w6_ones", 6'b111111, 1'b1);
        chk("w6_ones_g", bus6.g_out, 1'b1);
        chk("w6_ones_p", bus6.p_out, 1'b0);

        drive6(6'b000000, 6'b000000, 1'b0); tick();
        chk6("w6_zero", 6'b000000, 1'b0);
        chk("w6_zero_g", bus6.g_out, 1'b0);

        // Asynchronous reset between edges, then recovery
        drive6(6'b101110, 6'b100110, 1'b1); tick();
        chk6("w6_pre_rst", 6'b010101, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_vld",  bus6.out_valid, 1'b0);
        chk("arst_sum",  bus6.sum, 6'h00);
        chk("arst_cout", bus6.cout, 1'b0);
        chk("arst_g",    bus6.g_out, 1'b0);
        chk("arst_p",    bus6.p_out, 1'b0);
        tick();
        chk("arst_hold_vld", bus6.out_valid, 1'b0);
        chk("arst_hold_sum", bus6.sum, 6'h00);
        @(negedge clk);
        rst = 1'b0;
        drive6(6'b001100, 6'b011111, 1'b0); tick();
        chk6("w6_post_rst", 6'b101011, 1'b0);

        // Idle cycle: valid drops, result holds despite new operands
        bus6.in_valid = 1'b0;
        bus6.a = 6'b111111; bus6.b = 6'b111111; bus6.cin = 1'b1;
        tick();
        chk("idle_vld",  bus6.out_valid, 1'b0);
        chk("idle_sum",  bus6.sum, 6'b101011);
        chk("idle_cout", bus6.cout, 1'b0);
        chk("idle_p",    bus6.p_out, 1'b0);

        // Exhaustive WIDTH=4 sweep against a+b+cin
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive4(4'(a), 4'(b), 1'(c));
                    ref_full = 5'(a) + 5'(b) + 5'(c);
                    ref_gen  = 5'(a) + 5'(b);
                    tick();
                    chk("sweep_vld",  bus4.out_valid, 1'b1);
                    chk("sweep_sum",  bus4.sum, ref_full[3:0]);
                    chk("sweep_cout", bus4.cout, ref_full[4]);
                    chk("sweep_g",    bus4.g_out, ref_gen[4]);
                    chk("sweep_p",    bus4.p_out, (4'(a) ^ 4'(b)) == 4'hF);
                end
            end
        end
        bus4.in_valid = 1'b0;
        tick();
        chk("w4_idle_vld", bus4.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
